// File: rtl/pipelined_add_sub_pkg.sv
// Shared definitions for the pipelined add/subtract datapath.
//   ADD_OP / SUB_OP   : values of the 'sub' input selecting the operation
//   seg_width()       : bits handled by each pipeline segment (WIDTH/STAGES)
//   params_legal()    : true when WIDTH/STAGES form a legal combination
//   PAS_CHECK_PARAMS  : elaboration-time guard placed inside the top module
package pipelined_add_sub_pkg;

    localparam logic ADD_OP = 1'b0;
    localparam logic SUB_OP = 1'b1;

    function automatic int seg_width(input int width, input int stages);
        return (stages > 0) ? (width / stages) : width;
    endfunction

    function automatic bit params_legal(input int width, input int stages);
        return (stages >= 1) && (stages <= width) && ((width % stages) == 0);
    endfunction

endpackage

`define PAS_CHECK_PARAMS(W, S) \
    if (!pipelined_add_sub_pkg::params_legal((W), (S))) begin : g_param_check \
        $error("pipelined_add_sub: STAGES must satisfy 1 <= STAGES <= WIDTH and divide WIDTH"); \
    end

// File: rtl/pipelined_add_sub_adder_segment.sv
// Combinational ripple-carry building blocks.
//   full_adder    : a, b, cin -> sum, cout (one bit)
//   adder_segment : W-bit ripple of full_adder cells
//                   a, b [W-1:0], cin -> sum [W-1:0], cout
// The carry chain uses one local net per bit so no vector feeds back on itself.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);
    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));
endmodule

module adder_segment
    import pipelined_add_sub_pkg::*;
#(
    parameter int W = 4
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] sum,
    output logic         cout
);
    for (genvar i = 0; i < W; i++) begin : g_bit
        logic c_in_s;
        logic c_out_s;
        if (i == 0) begin : g_lsb
            assign c_in_s = cin;
        end else begin : g_upper
            assign c_in_s = g_bit[i-1].c_out_s;
        end
        full_adder u_fa (
            .a    (a[i]),
            .b    (b[i]),
            .cin  (c_in_s),
            .sum  (sum[i]),
            .cout (c_out_s)
        );
    end

    assign cout = g_bit[W-1].c_out_s;
endmodule

// File: rtl/pipelined_add_sub.sv
// Pipelined WIDTH-bit add/subtract with valid/ready handshakes.
//   clk, rst_n           : clock (rising edge), asynchronous active-low reset
//   in_valid / in_ready  : operand beat handshake (in_ready = !out_valid || out_ready)
//   a, b, carry_in, sub  : operands, carry into bit 0 (add only), 0 = add / 1 = sub
//   out_valid/out_ready  : result beat handshake
//   sum, carry_out       : WIDTH-bit result and carry out of the MSB (NOT borrow on sub)
//   overflow             : two's-complement signed overflow
// Stage k adds operand bits [k*SEG_W +: SEG_W] with the carry registered by stage k-1.
// Each stage forwards only the operand bits still to be added (shifted down so the
// next stage always reads its slice at [SEG_W-1:0]) and the result bits produced
// so far, so the registered result grows by SEG_W bits per stage.
// A single global stall holds every stage register while the output is blocked.
module pipelined_add_sub
    import pipelined_add_sub_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carry_in,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
    output logic             overflow
);
    localparam int SEG_W = seg_width(WIDTH, STAGES);
    localparam int LAST  = STAGES - 1;

    `PAS_CHECK_PARAMS(WIDTH, STAGES)

    logic advance_s;
    logic ovf_nxt_s;
    logic ovf_r;

    assign advance_s = !out_valid || out_ready;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int OPW  = WIDTH - k * SEG_W;   // operand bits still to add
        localparam int SUMW = (k + 1) * SEG_W;     // result bits known after this stage

        logic [OPW-1:0]   a_in_s;
        logic [OPW-1:0]   b_in_s;
        logic             c_in_s;
        logic             v_in_s;
        logic [SEG_W-1:0] seg_sum_s;
        logic             seg_cout_s;
        logic [SUMW-1:0]  sum_nxt_s;
        logic [SUMW-1:0]  sum_r;
        logic             c_r;
        logic             v_r;

        if (k == 0) begin : g_head
            // Subtraction folds into addition here: invert b and force the carry in.
            assign a_in_s    = a;
            assign b_in_s    = (sub == SUB_OP) ? ~b : b;
            assign c_in_s    = (sub == SUB_OP) ? 1'b1 : carry_in;
            assign v_in_s    = in_valid;
            assign sum_nxt_s = seg_sum_s;
        end else begin : g_body
            assign a_in_s    = g_stage[k-1].g_ops.a_r;
            assign b_in_s    = g_stage[k-1].g_ops.b_r;
            assign c_in_s    = g_stage[k-1].c_r;
            assign v_in_s    = g_stage[k-1].v_r;
            assign sum_nxt_s = {seg_sum_s, g_stage[k-1].sum_r};
        end

        adder_segment #(
            .W (SEG_W)
        ) u_seg (
            .a    (a_in_s[SEG_W-1:0]),
            .b    (b_in_s[SEG_W-1:0]),
            .cin  (c_in_s),
            .sum  (seg_sum_s),
            .cout (seg_cout_s)
        );

        // Stage valid, carry and partial result; all hold together on a stall.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                v_r   <= 1'b0;
                c_r   <= 1'b0;
                sum_r <= '0;
            end else if (advance_s) begin
                v_r   <= v_in_s;
                c_r   <= seg_cout_s;
                sum_r <= sum_nxt_s;
            end else begin
                v_r   <= v_r;
                c_r   <= c_r;
                sum_r <= sum_r;
            end
        end

        if (k < LAST) begin : g_ops
            logic [OPW-SEG_W-1:0] a_r;
            logic [OPW-SEG_W-1:0] b_r;

            // Operand bits not yet consumed, skewed one stage further down.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    a_r <= '0;
                    b_r <= '0;
                end else if (advance_s) begin
                    a_r <= a_in_s[OPW-1:SEG_W];
                    b_r <= b_in_s[OPW-1:SEG_W];
                end else begin
                    a_r <= a_r;
                    b_r <= b_r;
                end
            end
        end
    end

    // The last segment holds the operand MSBs (b already inverted for subtract).
    assign ovf_nxt_s = (g_stage[LAST].a_in_s[SEG_W-1] == g_stage[LAST].b_in_s[SEG_W-1]) &&
                       (g_stage[LAST].seg_sum_s[SEG_W-1] != g_stage[LAST].a_in_s[SEG_W-1]);

    // Signed overflow flag, registered alongside the final stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_r <= 1'b0;
        end else if (advance_s) begin
            ovf_r <= ovf_nxt_s;
        end else begin
            ovf_r <= ovf_r;
        end
    end

    assign in_ready  = advance_s;
    assign out_valid = g_stage[LAST].v_r;
    assign sum       = g_stage[LAST].sum_r;
    assign carry_out = g_stage[LAST].c_r;
    assign overflow  = ovf_r;

endmodule

// File: tb/tb_pipelined_add_sub.sv
// Self-checking bench for pipelined_add_sub (WIDTH=16, STAGES=4).
// Expected results come from a behavioural model and travel through a queue
// that is filled on input handshakes and drained on output handshakes.
module tb_pipelined_add_sub;
    localparam int W  = 16;
    localparam int ST = 4;

    typedef struct packed {
        logic [W-1:0] s;
        logic         c;
        logic         o;
    } exp_t;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         carry_in;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         carry_out;
    logic         overflow;

    int   n_checks = 0;
    int   n_errors = 0;
    int   n_pops   = 0;
    int   cyc      = 0;
    bit   rand_rdy = 1'b0;
    exp_t sb_q[$];

    pipelined_add_sub #(
        .WIDTH  (W),
        .STAGES (ST)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .carry_in  (carry_in),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .carry_out (carry_out),
        .overflow  (overflow)
    );

    // Free-running clock, 10 ns period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Cycle counter used for throughput measurement.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [W-1:0] op_a, input logic [W-1:0] op_b,
                                   input logic cin, input logic op_sub);
        exp_t         e;
        logic [W:0]   full;
        logic [W-1:0] b_eff;
        logic         c0;
        b_eff = op_sub ? ~op_b : op_b;
        c0    = op_sub ? 1'b1 : cin;
        full  = {1'b0, op_a} + {1'b0, b_eff} + {{W{1'b0}}, c0};
        e.s   = full[W-1:0];
        e.c   = full[W];
        e.o   = (op_a[W-1] == b_eff[W-1]) && (full[W-1] != op_a[W-1]);
        return e;
    endfunction

    // Scoreboard: compare on output handshake, enqueue on input handshake.
    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid && out_ready) begin
                if (sb_q.size() == 0) begin
                    check_val("unexpected_out", 64'd1, 64'd0);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    n_pops++;
                    check_val("sb_sum", {48'd0, sum}, {48'd0, e.s});
                    check_val("sb_carry", {63'd0, carry_out}, {63'd0, e.c});
                    check_val("sb_ovf", {63'd0, overflow}, {63'd0, e.o});
                end
            end
            if (in_valid && in_ready) begin
                sb_q.push_back(model(a, b, carry_in, sub));
            end
        end
    end

    // Random back-pressure when enabled.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
        end
    end

    // Watchdog against any hang.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic send_beat(input logic [W-1:0] va, input logic [W-1:0] vb,
                             input logic vc, input logic vs);
        bit acc;
        acc      = 1'b0;
        a        = va;
        b        = vb;
        carry_in = vc;
        sub      = vs;
        in_valid = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            if (acc) break;
        end
        if (!acc) check_val("accept_timeout", 64'd0, 64'd1);
        in_valid = 1'b0;
    endtask

    task automatic run_single(input string tag, input logic [W-1:0] va, input logic [W-1:0] vb,
                              input logic vc, input logic vs, input logic [W-1:0] es,
                              input logic ec, input logic eo);
        int n;
        send_beat(va, vb, vc, vs);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!out_valid && n < 20);
        check_val({tag, "_valid"}, {63'd0, out_valid}, 64'd1);
        check_val({tag, "_sum"}, {48'd0, sum}, {48'd0, es});
        check_val({tag, "_carry"}, {63'd0, carry_out}, {63'd0, ec});
        check_val({tag, "_ovf"}, {63'd0, overflow}, {63'd0, eo});
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        for (int i = 0; i < 500; i++) begin
            if (sb_q.size() == 0) break;
            @(posedge clk);
            #1;
        end
        check_val("drain_empty", 64'(sb_q.size()), 64'd0);
    endtask

    initial begin
        int   c0;
        int   p0;
        logic [W-1:0] held_sum;
        logic held_c;
        logic held_o;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        carry_in  = 1'b0;
        sub       = 1'b0;
        out_ready = 1'b1;

        // Reset state
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;
        @(negedge clk);
        check_val("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check_val("rst_in_ready", {63'd0, in_ready}, 64'd1);
        check_val("rst_sum", {48'd0, sum}, 64'd0);
        check_val("rst_carry", {63'd0, carry_out}, 64'd0);
        check_val("rst_ovf", {63'd0, overflow}, 64'd0);
        @(posedge clk);
        #1;

        // Latency: three empty cycles, result on the fourth
        send_beat(16'h1234, 16'h1111, 1'b1, 1'b0);
        for (int i = 0; i < ST - 1; i++) begin
            @(negedge clk);
            check_val("lat_idle", {63'd0, out_valid}, 64'd0);
        end
        @(negedge clk);
        check_val("lat_valid", {63'd0, out_valid}, 64'd1);
        check_val("lat_sum", {48'd0, sum}, 64'h2346);
        check_val("lat_carry", {63'd0, carry_out}, 64'd0);
        check_val("lat_ovf", {63'd0, overflow}, 64'd0);
        @(posedge clk);
        #1;

        // Wrap-around, overflow and subtract corners
        run_single("wrap", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        run_single("addovf", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
        run_single("subneg", 16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        run_single("subovf", 16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);

        // Unstalled throughput: 8 beats in 8 cycles
        c0 = cyc;
        for (int i = 0; i < 8; i++) send_beat(16'(i * 16'h0101), 16'(16'h0F00 + i), 1'b0, 1'(i & 1));
        check_val("throughput_cycles", 64'(cyc - c0), 64'd8);
        drain();

        // Back-pressure mid-stream
        p0 = n_pops;
        fork
            begin
                for (int i = 0; i < 8; i++) begin
                    send_beat(16'(16'h1000 * i + 16'h0123), 16'(16'h0F0F + i), 1'(i & 1), 1'((i >> 1) & 1));
                end
            end
            begin
                repeat (5) @(posedge clk);
                #1 out_ready = 1'b0;
                @(negedge clk);
                held_sum = sum;
                held_c   = carry_out;
                held_o   = overflow;
                check_val("stall_in_ready", {63'd0, in_ready}, 64'd0);
                check_val("stall_out_valid", {63'd0, out_valid}, 64'd1);
                for (int i = 0; i < 4; i++) begin
                    @(negedge clk);
                    check_val("stall_in_ready", {63'd0, in_ready}, 64'd0);
                    check_val("stall_sum_hold", {48'd0, sum}, {48'd0, held_sum});
                    check_val("stall_carry_hold", {63'd0, carry_out}, {63'd0, held_c});
                    check_val("stall_ovf_hold", {63'd0, overflow}, {63'd0, held_o});
                end
                @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        drain();
        check_val("stall_result_count", 64'(n_pops - p0), 64'd8);

        // Asynchronous reset with beats in flight
        send_beat(16'h0101, 16'h0202, 1'b0, 1'b0);
        send_beat(16'h0303, 16'h0404, 1'b1, 1'b0);
        send_beat(16'h0505, 16'h0606, 1'b0, 1'b1);
        @(posedge clk);
        #3;
        check_val("midrst_pre_valid", {63'd0, out_valid}, 64'd1);
        rst_n = 1'b0;
        #1;
        check_val("midrst_valid_drop", {63'd0, out_valid}, 64'd0);
        sb_q.delete();
        #2 rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check_val("midrst_no_stale", {63'd0, out_valid}, 64'd0);
        end
        @(posedge clk);
        #1;

        // Random traffic with random back-pressure
        rand_rdy = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end
            send_beat(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        rand_rdy = 1'b0;
        @(posedge clk);
        #1 out_ready = 1'b1;
        drain();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
